ones_frame_stats: RTL and testbench
===================================

// Module: ones_frame_stats
// PURPOSE
//   Downstream consumer of the 10-bit ones-counter (`one`). Collects its 5-bit popcount
//   results over a frame of FRAME_LEN samples using a valid/ready input handshake.
//   Per frame it reports sum, max, min and sample count, held on a valid/ready output
//   until taken. Sits between the popcount stage and the stats/readout logic.
// PARAMETERS
//   CNT_W      5   width of each incoming popcount sample
//   FRAME_LEN  8   samples per full frame, >=2
//   SUM_W      8   sum width; must be >= CNT_W+clog2(FRAME_LEN)
//   THRESH     8   alarm threshold, used only when ONES_ALARM_EN is defined
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      in_ones is valid
//   in_ready   out  1      block can accept a sample
//   in_ones    in   CNT_W  popcount sample from the ones counter
//   flush      in   1      close a partial frame early
//   out_valid  out  1      frame result is valid
//   out_ready  in   1      consumer takes the result
//   out_sum    out  SUM_W  sum of the samples in the frame
//   out_max    out  CNT_W  largest sample in the frame
//   out_min    out  CNT_W  smallest sample in the frame
//   out_cnt    out  8      number of samples in the frame (1..FRAME_LEN)
//   out_alarm  out  8      samples >= THRESH (present only with ONES_ALARM_EN)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=ACCUM. in_ready=1 after reset. out_valid=0.
//     All out_* = 0. Internal sum/max/cnt = 0. Internal min = all-ones.
//   FSM: ACCUM, HOLD. in_ready = (state==ACCUM). out_valid = (state==HOLD).
//   Accept: in_valid & in_ready at a clock edge.
//     sum += in_ones; max/min updated; cnt += 1.
//   ACCUM->HOLD, either case:
//     - the accept that makes cnt==FRAME_LEN;
//     - flush=1 while cnt>0 (cnt counted after any same-cycle accept).
//   On that edge, out_* are registered from the values that include the current
//   sample, so out_valid rises on the edge of the last accepted sample.
//   Internal accumulators then clear to their reset values.
//   flush with cnt==0 and no same-cycle accept: ignored, no empty frame emitted.
//   HOLD: in_ready=0. All out_* stay stable until out_valid & out_ready.
//     Then state=ACCUM the next cycle, with in_ready=1 and out_valid=0.
//     out_* keep their last values; they are meaningful only while out_valid=1.
//   flush in HOLD: ignored. in_valid in HOLD: not accepted; the source must hold it.
//   Samples are unsigned and used as-is, with no clamp to 10.
//     Sum adds modulo 2^SUM_W; the SUM_W rule above prevents overflow.
//   Reset mid-frame or in HOLD: partial frame and pending result are discarded.
// CONFIGURATION
//   ONES_ALARM_EN defined:
//     An extra counter increments on each accept with in_ones >= THRESH.
//     It is registered to out_alarm alongside the other results and clears per frame.
//   ONES_ALARM_EN undefined:
//     No out_alarm port and no counter logic. All other behaviour is identical.
// TESTING (FRAME_LEN=4, SUM_W=8, THRESH=8)
//   Full frame: samples 10,8,8,1, back-to-back, out_ready=1.
//     -> out_valid on the 4th accept edge, sum=27, max=10, min=1, cnt=4
//     -> with the macro, alarm=3.
//   Backpressure: out_ready=0 for 5 cycles after a frame, in_valid held with in_ones=5.
//     -> in_ready=0 and outputs stable in HOLD; the 5 is accepted only after the
//        out_valid & out_ready cycle.
//   Flush with accept: samples 0,31 with flush=1 in the same cycle as 31.
//     -> sum=31, max=31, min=0, cnt=2.
//   Idle flush: flush alone with cnt=0 -> out_valid stays 0.
//   Reset mid-frame: 2 samples, then rst_n low -> all outputs 0.
//     Next full frame 1,1,1,1 -> sum=4, min=1, max=1.
//   Gapped input: in_valid toggling every other cycle, 4 samples of 10.
//     -> sum=40, cnt=4, max=min=10.

Source files
------------

// File: rtl/ones_frame_stats.sv
// Frame statistics (sum/max/min/count) over popcount samples, valid/ready on both sides.
// Optional alarm counter (out_alarm) is built only when ONES_ALARM_EN is defined.
module ones_frame_stats #(
  parameter int CNT_W     = 5,
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_ones,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_max,
  output logic [CNT_W-1:0] out_min,
  output logic [7:0]       out_cnt
`ifdef ONES_ALARM_EN
  ,
  output logic [7:0]       out_alarm
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] FRAME_LEN_V = 8'(FRAME_LEN);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, sum_n;
  logic [CNT_W-1:0] max_q, max_d, max_n;
  logic [CNT_W-1:0] min_q, min_d, min_n;
  logic [7:0]       cnt_q, cnt_d, cnt_n;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_max_q, out_max_d;
  logic [CNT_W-1:0] out_min_q, out_min_d;
  logic [7:0]       out_cnt_q, out_cnt_d;
  logic             accept;
  logic             close_frame;

`ifdef ONES_ALARM_EN
  localparam logic [CNT_W:0] THRESH_V = (CNT_W+1)'(THRESH);
  logic [7:0] alarm_q, alarm_d, alarm_n;
  logic [7:0] out_alarm_q, out_alarm_d;
`endif

  // "_n" values include the sample accepted this cycle, so a closing frame
  // reports the last sample on the same edge it is taken.
  always_comb begin
    accept = in_valid && (state_q == ACCUM);
    sum_n  = sum_q + (accept ? {{(SUM_W-CNT_W){1'b0}}, in_ones} : '0);
    max_n  = (accept && (in_ones > max_q)) ? in_ones : max_q;
    min_n  = (accept && (in_ones < min_q)) ? in_ones : min_q;
    cnt_n  = cnt_q + {7'd0, accept};
`ifdef ONES_ALARM_EN
    alarm_n = alarm_q + {7'd0, (accept && ({1'b0, in_ones} >= THRESH_V))};
`endif
    close_frame = (state_q == ACCUM) &&
                  ((accept && (cnt_n == FRAME_LEN_V)) || (flush && (cnt_n != 8'd0)));

    state_d   = state_q;
    sum_d     = sum_q;
    max_d     = max_q;
    min_d     = min_q;
    cnt_d     = cnt_q;
    out_sum_d = out_sum_q;
    out_max_d = out_max_q;
    out_min_d = out_min_q;
    out_cnt_d = out_cnt_q;
`ifdef ONES_ALARM_EN
    alarm_d     = alarm_q;
    out_alarm_d = out_alarm_q;
`endif

    case (state_q)
      ACCUM: begin
        if (close_frame) begin
          state_d   = HOLD;
          out_sum_d = sum_n;
          out_max_d = max_n;
          out_min_d = min_n;
          out_cnt_d = cnt_n;
          sum_d     = '0;
          max_d     = '0;
          min_d     = '1;
          cnt_d     = 8'd0;
`ifdef ONES_ALARM_EN
          out_alarm_d = alarm_n;
          alarm_d     = 8'd0;
`endif
        end else begin
          sum_d = sum_n;
          max_d = max_n;
          min_d = min_n;
          cnt_d = cnt_n;
`ifdef ONES_ALARM_EN
          alarm_d = alarm_n;
`endif
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      max_q     <= '0;
      min_q     <= '1;
      cnt_q     <= 8'd0;
      out_sum_q <= '0;
      out_max_q <= '0;
      out_min_q <= '0;
      out_cnt_q <= 8'd0;
`ifdef ONES_ALARM_EN
      alarm_q     <= 8'd0;
      out_alarm_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      out_sum_q <= out_sum_d;
      out_max_q <= out_max_d;
      out_min_q <= out_min_d;
      out_cnt_q <= out_cnt_d;
`ifdef ONES_ALARM_EN
      alarm_q     <= alarm_d;
      out_alarm_q <= out_alarm_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_min   = out_min_q;
  assign out_cnt   = out_cnt_q;
`ifdef ONES_ALARM_EN
  assign out_alarm = out_alarm_q;
`endif

endmodule

// File: tb/tb_ones_frame_stats.sv
// Directed bench for ones_frame_stats with FRAME_LEN=4, SUM_W=8, THRESH=8.
module tb_ones_frame_stats;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_ones;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [4:0] out_max;
  logic [4:0] out_min;
  logic [7:0] out_cnt;
`ifdef ONES_ALARM_EN
  logic [7:0] out_alarm;
`endif

  int checks;
  int failures;

  ones_frame_stats #(
    .CNT_W(5), .FRAME_LEN(4), .SUM_W(8), .THRESH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ones(in_ones),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_max(out_max),
    .out_min(out_min),
    .out_cnt(out_cnt)
`ifdef ONES_ALARM_EN
    ,
    .out_alarm(out_alarm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one sample from a falling edge and holds it until it is taken.
  task automatic send(input logic [4:0] val, input logic fl);
    int waited;
    logic was_ready;
    @(negedge clk);
    in_valid = 1'b1;
    in_ones  = val;
    flush    = fl;
    waited   = 0;
    was_ready = in_ready;
    @(posedge clk);
    while (!was_ready && waited < 20) begin
      waited++;
      @(negedge clk);
      was_ready = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (!was_ready) begin
      checks++; failures++;
      $display("[TB] FAIL send_timeout got=in_ready_low exp=accept_within_20");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_ones = 5'd0; flush = 1'b0; out_ready = 1'b1;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got=%0d exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%0d exp=0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin failures++; $display("[TB] FAIL rst_out_sum got=%0d exp=0", out_sum); end
    checks++; if (out_min !== 5'd0) begin failures++; $display("[TB] FAIL rst_out_min got=%0d exp=0", out_min); end
    checks++; if (out_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_out_cnt got=%0d exp=0", out_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_in_ready got=%0d exp=1", in_ready); end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    send(5'd10, 1'b0); send(5'd8, 1'b0); send(5'd8, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_early_valid got=%0d exp=0", out_valid); end
    send(5'd1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_valid got=%0d exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_in_ready got=%0d exp=0", in_ready); end
    checks++; if (out_sum !== 8'd27) begin failures++; $display("[TB] FAIL full_sum got=%0d exp=27", out_sum); end
    checks++; if (out_max !== 5'd10) begin failures++; $display("[TB] FAIL full_max got=%0d exp=10", out_max); end
    checks++; if (out_min !== 5'd1) begin failures++; $display("[TB] FAIL full_min got=%0d exp=1", out_min); end
    checks++; if (out_cnt !== 8'd4) begin failures++; $display("[TB] FAIL full_cnt got=%0d exp=4", out_cnt); end
`ifdef ONES_ALARM_EN
    checks++; if (out_alarm !== 8'd3) begin failures++; $display("[TB] FAIL full_alarm got=%0d exp=3", out_alarm); end
`endif
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_release_valid got=%0d exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_release_ready got=%0d exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(5'd2, 1'b0); send(5'd2, 1'b0); send(5'd2, 1'b0); send(5'd2, 1'b0);
    checks++; if (out_sum !== 8'd8) begin failures++; $display("[TB] FAIL bp_sum got=%0d exp=8", out_sum); end
    @(negedge clk); in_valid = 1'b1; in_ones = 5'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_ready cyc=%0d got=%0d exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%0d exp=1", i, out_valid); end
      checks++; if (out_sum !== 8'd8 || out_cnt !== 8'd4 || out_max !== 5'd2 || out_min !== 5'd2) begin
        failures++; $display("[TB] FAIL bp_hold_stable cyc=%0d got=%0d/%0d/%0d/%0d exp=8/4/2/2", i, out_sum, out_cnt, out_max, out_min);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid got=%0d exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%0d exp=1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_late_valid got=%0d exp=1", out_valid); end
    checks++; if (out_sum !== 8'd5) begin failures++; $display("[TB] FAIL bp_late_sum got=%0d exp=5", out_sum); end
    checks++; if (out_cnt !== 8'd1) begin failures++; $display("[TB] FAIL bp_late_cnt got=%0d exp=1", out_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_accept();
    send(5'd0, 1'b0);
    send(5'd31, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_valid got=%0d exp=1", out_valid); end
    checks++; if (out_sum !== 8'd31) begin failures++; $display("[TB] FAIL flush_sum got=%0d exp=31", out_sum); end
    checks++; if (out_max !== 5'd31) begin failures++; $display("[TB] FAIL flush_max got=%0d exp=31", out_max); end
    checks++; if (out_min !== 5'd0) begin failures++; $display("[TB] FAIL flush_min got=%0d exp=0", out_min); end
    checks++; if (out_cnt !== 8'd2) begin failures++; $display("[TB] FAIL flush_cnt got=%0d exp=2", out_cnt); end
`ifdef ONES_ALARM_EN
    checks++; if (out_alarm !== 8'd1) begin failures++; $display("[TB] FAIL flush_alarm got=%0d exp=1", out_alarm); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_idle_flush();
    @(negedge clk); flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_flush_valid cyc=%0d got=%0d exp=0", i, out_valid); end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send(5'd3, 1'b0); send(5'd4, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++; if (out_sum !== 8'd0) begin failures++; $display("[TB] FAIL midrst_sum got=%0d exp=0", out_sum); end
    checks++; if (out_max !== 5'd0) begin failures++; $display("[TB] FAIL midrst_max got=%0d exp=0", out_max); end
    checks++; if (out_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midrst_cnt got=%0d exp=0", out_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%0d exp=0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    send(5'd1, 1'b0); send(5'd1, 1'b0); send(5'd1, 1'b0); send(5'd1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_frame_valid got=%0d exp=1", out_valid); end
    checks++; if (out_sum !== 8'd4) begin failures++; $display("[TB] FAIL midrst_frame_sum got=%0d exp=4", out_sum); end
    checks++; if (out_min !== 5'd1) begin failures++; $display("[TB] FAIL midrst_frame_min got=%0d exp=1", out_min); end
    checks++; if (out_max !== 5'd1) begin failures++; $display("[TB] FAIL midrst_frame_max got=%0d exp=1", out_max); end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 4; i++) begin
      send(5'd10, 1'b0);
      if (i < 3) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL gap_early_valid i=%0d got=%0d exp=0", i, out_valid); end
        @(posedge clk); #1;
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL gap_valid got=%0d exp=1", out_valid); end
    checks++; if (out_sum !== 8'd40) begin failures++; $display("[TB] FAIL gap_sum got=%0d exp=40", out_sum); end
    checks++; if (out_cnt !== 8'd4) begin failures++; $display("[TB] FAIL gap_cnt got=%0d exp=4", out_cnt); end
    checks++; if (out_max !== 5'd10) begin failures++; $display("[TB] FAIL gap_max got=%0d exp=10", out_max); end
    checks++; if (out_min !== 5'd10) begin failures++; $display("[TB] FAIL gap_min got=%0d exp=10", out_min); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_flush_accept();
    test_idle_flush();
    test_reset_midframe();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
